// File: rtl/exp_normalizer.sv
// exp_normalizer
// Registered exponent-normalization stage of the FPU rounder.
// It subtracts the leading-zero count from the pre-normalization exponent.
// When a trap is enabled, it also applies IEEE exponent wrapping (+/- alpha).
// It produces the normalized exponent and its incremented twin, one cycle later.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   inputs valid this cycle
//   er[10:0]   pre-normalization exponent (mod 2^11)
//   lz[5:0]    leading-zero count (unsigned)
//   db         1 = double precision, 0 = single precision
//   OVFen/OVF1 overflow trap enable / overflow-before-rounding
//   UNFen/TINY underflow trap enable / tiny result
//   out_valid  en/eni/flags hold a new result
//   en[10:0]   normalized (optionally wrapped) exponent
//   eni[10:0]  en + 1 under the same masking
//   ovf_wrap   overflow wrapping applied
//   unf_wrap   underflow wrapping applied
module exp_normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [10:0] er,
  input  logic [5:0]  lz,
  input  logic        db,
  input  logic        OVFen,
  input  logic        OVF1,
  input  logic        UNFen,
  input  logic        TINY,
  output logic        out_valid,
  output logic [10:0] en,
  output logic [10:0] eni,
  output logic        ovf_wrap,
  output logic        unf_wrap
);

  localparam logic [10:0] ALPHA_DB = 11'h600;
  localparam logic [10:0] ALPHA_SP = 11'h0C0;

  logic        out_valid_q, out_valid_d;
  logic [10:0] en_q, en_d;
  logic [10:0] eni_q, eni_d;
  logic        ovf_wrap_q, ovf_wrap_d;
  logic        unf_wrap_q, unf_wrap_d;

  logic        ovf_sel;
  logic        unf_sel;
  logic [10:0] alpha;
  logic [10:0] adj;
  logic [10:0] base;
  logic [10:0] t;
  logic [10:0] ti;

  always_comb begin
    ovf_sel = OVFen & OVF1;
    // Overflow wins when both wrap conditions are present.
    unf_sel = UNFen & TINY & ~ovf_sel;
    alpha   = db ? ALPHA_DB : ALPHA_SP;
    // Signed wrap adjustment folded into a single addend (mod 2^11).
    if (ovf_sel) begin
      adj = 11'd0 - alpha;
    end else if (unf_sel) begin
      adj = alpha;
    end else begin
      adj = 11'd0;
    end
    base = er - {5'b00000, lz} + adj;
    // t and t+1 share the operand tree; ti is formed from the unmasked sum,
    // never from the masked en, so single precision wraps mod 256 correctly.
    t  = base;
    ti = base + 11'd1;
  end

  always_comb begin
    out_valid_d = in_valid;
    en_d        = en_q;
    eni_d       = eni_q;
    ovf_wrap_d  = ovf_wrap_q;
    unf_wrap_d  = unf_wrap_q;
    if (in_valid) begin
      en_d       = db ? t  : {3'b000, t[7:0]};
      eni_d      = db ? ti : {3'b000, ti[7:0]};
      ovf_wrap_d = ovf_sel;
      unf_wrap_d = unf_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      en_q        <= 11'd0;
      eni_q       <= 11'd0;
      ovf_wrap_q  <= 1'b0;
      unf_wrap_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      en_q        <= en_d;
      eni_q       <= eni_d;
      ovf_wrap_q  <= ovf_wrap_d;
      unf_wrap_q  <= unf_wrap_d;
    end
  end

  assign out_valid = out_valid_q;
  assign en        = en_q;
  assign eni       = eni_q;
  assign ovf_wrap  = ovf_wrap_q;
  assign unf_wrap  = unf_wrap_q;

endmodule

// File: tb/tb_exp_normalizer.sv
// Testbench for exp_normalizer.
// Directed steps from the test plan are followed by randomized operations.
// An integer-arithmetic reference model supplies every expected value.
module tb_exp_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [10:0] er;
  logic [5:0]  lz;
  logic        db;
  logic        OVFen, OVF1, UNFen, TINY;
  logic        out_valid;
  logic [10:0] en, eni;
  logic        ovf_wrap, unf_wrap;

  int tests = 0;
  int fails = 0;

  // reference model state
  int exp_ov = 0, exp_en = 0, exp_eni = 0, exp_ow = 0, exp_uw = 0;

  exp_normalizer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .er(er), .lz(lz), .db(db),
    .OVFen(OVFen), .OVF1(OVF1), .UNFen(UNFen), .TINY(TINY),
    .out_valid(out_valid), .en(en), .eni(eni),
    .ovf_wrap(ovf_wrap), .unf_wrap(unf_wrap)
  );

  always #5 clk = ~clk;

  function automatic int modn(int x, int n);
    return ((x % n) + n) % n;
  endfunction

  task automatic check(string tag, int obs, int expv);
    tests++;
    assert (obs === expv)
      else begin
        fails++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
  endtask

  // Apply one cycle of inputs, update the model, then check all outputs.
  task automatic step(string tag, bit r, bit v, int e, int l, bit d,
                      bit oen, bit o1, bit uen, bit ty);
    int alpha, ow, uw, raw;
    rst = r; in_valid = v; er = 11'(e); lz = 6'(l); db = d;
    OVFen = oen; OVF1 = o1; UNFen = uen; TINY = ty;
    @(posedge clk);
    #1;
    if (r) begin
      exp_ov = 0; exp_en = 0; exp_eni = 0; exp_ow = 0; exp_uw = 0;
    end else if (v) begin
      alpha = d ? 1536 : 192;
      ow = (oen && o1) ? 1 : 0;
      uw = (uen && ty && ow == 0) ? 1 : 0;
      raw = e - l - ow * alpha + uw * alpha;
      exp_en  = modn(raw, d ? 2048 : 256);
      exp_eni = modn(raw + 1, d ? 2048 : 256);
      exp_ow = ow; exp_uw = uw; exp_ov = 1;
    end else begin
      exp_ov = 0;
    end
    check({tag, ".out_valid"}, int'(out_valid), exp_ov);
    check({tag, ".en"}, int'(en), exp_en);
    check({tag, ".eni"}, int'(eni), exp_eni);
    check({tag, ".ovf_wrap"}, int'(ovf_wrap), exp_ow);
    check({tag, ".unf_wrap"}, int'(unf_wrap), exp_uw);
    $display("[TB] %s rst=%0b v=%0b er=%0d lz=%0d db=%0b -> ov=%0b en=%0d eni=%0d ow=%0b uw=%0b",
             tag, r, v, e, l, d, out_valid, en, eni, ovf_wrap, unf_wrap);
  endtask

  initial begin
    step("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Explicit constant checks from the test plan, alongside the model.
    step("sp_basic", 0, 1, 1, 1, 0, 0, 0, 0, 0);
    check("sp_basic.const_en", int'(en), 0);
    check("sp_basic.const_eni", int'(eni), 1);
    step("sp_ovf", 0, 1, 1, 1, 0, 1, 1, 0, 0);
    check("sp_ovf.const_en", int'(en), 64);
    check("sp_ovf.const_eni", int'(eni), 65);
    step("sp_ovf_prio", 0, 1, 1, 1, 0, 1, 1, 1, 1);
    check("sp_ovf_prio.const_en", int'(en), 64);
    check("sp_ovf_prio.const_uw", int'(unf_wrap), 0);
    step("sp_unf", 0, 1, 1, 1, 0, 0, 0, 1, 1);
    check("sp_unf.const_en", int'(en), 192);
    check("sp_unf.const_eni", int'(eni), 193);
    step("dp_basic", 0, 1, 12, 6, 1, 0, 0, 0, 0);
    check("dp_basic.const_en", int'(en), 6);
    step("dp_nowrap", 0, 1, 'h555, 51, 1, 1, 0, 0, 1);
    check("dp_nowrap.const_en", int'(en), 'h522);
    check("dp_nowrap.const_eni", int'(eni), 'h523);
    step("dp_max", 0, 1, 'h7FF, 0, 1, 0, 0, 0, 0);
    check("dp_max.const_en", int'(en), 'h7FF);
    check("dp_max.const_eni", int'(eni), 0);
    step("dp_under", 0, 1, 0, 1, 1, 0, 0, 0, 0);
    check("dp_under.const_en", int'(en), 'h7FF);
    step("dp_ovf", 0, 1, 'h100, 0, 1, 1, 1, 0, 0);
    check("dp_ovf.const_en", int'(en), 'h300);
    step("dp_unf", 0, 1, 'h700, 3, 1, 0, 0, 1, 1);
    step("sp_eni_wrap", 0, 1, 255, 0, 0, 0, 0, 0, 0);
    check("sp_eni_wrap.const_eni", int'(eni), 0);

    step("idle0", 0, 0, 5, 5, 1, 0, 0, 0, 0);
    step("idle1", 0, 0, 9, 2, 0, 1, 1, 0, 0);
    step("reload", 0, 1, 'h3AB, 17, 1, 0, 0, 1, 1);
    step("rst_vs_valid", 1, 1, 'h123, 4, 1, 1, 1, 0, 0);
    check("rst_vs_valid.const_ov", int'(out_valid), 0);
    step("after_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 2047)), int'($urandom_range(0, 63)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
